des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Upstream neighbour of the DES F-function: expands one 64-bit key into the 16 48-bit round subkeys.
//  Subkeys are issued one per valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
//  The issued subkey drives the round stage's Keyin [1:48]. Bit 1 is the MSB, per the DES numbering.
// PARAMETERS
//  PARITY_CHK  0  1: check odd parity of each key byte at load; 0: parity bits ignored, parity_err tied 0
// PORTS
//  sys_clk       in   1   single clock; all state on rising edge
//  sys_rst_n     in   1   asynchronous, active-low reset
//  key_in        in   64  [1:64] DES key incl. parity bits 8,16..64
//  decrypt       in   1   sampled with key_in: 0 = K1..K16, 1 = K16..K1
//  key_valid     in   1   key_in/decrypt valid
//  key_ready     out  1   high only in IDLE; load occurs on key_valid&&key_ready
//  subkey        out  48  [1:48] PC2(C,D) of current round
//  subkey_round  out  4   round index 0..15 (round 1 = 0), counts 0..15 in both modes
//  subkey_valid  out  1   subkey/subkey_round valid
//  subkey_ready  in   1   consumer accepts on subkey_valid&&subkey_ready
//  parity_err    out  1   sticky per key: set at load if any byte has even parity
//  busy          out  1   high in RUN
// BEHAVIOUR
//  Reset: key_ready=1, subkey_valid=0, subkey=0, subkey_round=0, parity_err=0, busy=0, C/D=0, FSM=IDLE.
//  FSM: IDLE -(key_valid&&key_ready)-> RUN -(handshake with subkey_round==15)-> IDLE.
//  Load: C,D <= PC1(key_in) with the first shift already applied: encrypt rotl1; decrypt no shift.
//   Also latch decrypt; round<=0; parity_err<=PARITY_CHK & |(byte even parity); busy=1.
//  Latency: subkey_valid=1 in the cycle after load. subkey is a combinational PC2 of the C/D registers.
//  Per handshake: round<=round+1; encrypt rotl C,D by 1 for next rounds 2,9,16, else by 2.
//   Decrypt rotr C,D by 1 for next rounds 2,9,16, else by 2. Rotations are 28-bit wrap.
//   After 16 encrypt rotations (28 total) C,D return to PC1 value.
//  Stall: subkey_valid&&!subkey_ready holds subkey, subkey_round and C/D unchanged. No bubbles.
//  Final handshake (round 15): subkey_valid<=0, busy<=0, key_ready<=1 next cycle.
//   Next key is accepted no earlier than 1 cycle after the last subkey.
//  key_valid while in RUN: ignored (key_ready=0). decrypt changes in RUN: ignored (latched copy used).
//  parity_err: a load is never blocked; it holds until the next load or reset.
//  Reset mid-RUN: immediately to reset values. No partial subkeys after release.
//  subkey_round does not wrap within a key; 16 handshakes exactly per load.
// STRUCTURE
//  des_defines.vh (shared):
//   - PC1 table (56 entries) and PC2 table (48 entries)
//   - SHIFT schedule {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}
//   - ROUNDS=16; FSM state encodings IDLE/RUN
//  Sub-module des_pc2: purely combinational 56->48 permutation.
//   Reusable by any later unrolled or pipelined key path.
//  Rest in this file: PC1, rotate muxes, round counter, FSM, parity reduction.
// TESTING
//  1. Key 133457799BBCDFF1, decrypt=0, subkey_ready=1:
//     K1 = 1B02EFFC7072 (round 0), one cycle after load; K16 = CB3D8B0E17F5 (round 15);
//     key_ready=1 the cycle after; parity_err=0.
//  2. Same key, decrypt=1: the round 0 subkey is CB3D8B0E17F5 and the round 15 subkey is 1B02EFFC7072.
//     The full sequence is the exact reverse of scenario 1.
//  3. Random subkey_ready backpressure (~50%) on scenario 1:
//     the 16 accepted subkeys match scenario 1 in order; values stable during every stall.
//  4. Key 0000000000000000 with PARITY_CHK=1 -> parity_err=1 and the schedule still completes.
//     Then load 133457799BBCDFF1 -> parity_err=0.
//  5. Assert key_valid with a different key while at round 7:
//     no load, sequence continues unchanged; the new key is accepted only after round 15 is handshaken.
//  6. sys_rst_n low at round 5:
//     all outputs go to reset values asynchronously; after release, key_ready=1 and subkey_valid=0
//     until the next load.

Source files
------------

// File: rtl/des_key_schedule_pkg.sv
// Shared tables, state encoding and helpers for the DES key schedule.
package des_key_schedule_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  // Permuted choice 1: key bit positions (1 = MSB), C half then D half.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: positions within C||D (1 = MSB of C).
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied before each encrypt round.
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    return cd;
  endfunction

  // The step leaving round r is a single-bit rotation in both directions:
  // decrypt walks the table backwards, and the table is symmetric about
  // the single-shift positions seen from r+1.
  function automatic logic single_shift(input logic [3:0] r);
    return SHIFT_TAB[r + 4'd1] == 1;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic one);
    logic [27:0] y;
    if (left) y = one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    else      y = one ? {x[0], x[27:1]}  : {x[1:0], x[27:2]};
    return y;
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left, input logic one);
    return {rot28(cd[55:28], left, one), rot28(cd[27:0], left, one)};
  endfunction

  // High when any key byte carries even parity (DES keys use odd parity).
  function automatic logic any_even_byte(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) if (~^key[6'(8 * k) +: 8]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// Combinational PC2 selection: 56-bit C||D to one 48-bit round subkey.
module des_key_schedule_pc2
  import des_key_schedule_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  // Pick the 48 subkey bits out of C||D; bit 1 of the subkey is the MSB.
  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) subkey_o[6'(47 - i)] = cd_i[6'(56 - PC2_TAB[i])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: loads one 64-bit key and issues the 16 round subkeys,
// one per valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for a key; key_ready high
//   ST_RUN  | presenting subkey for round round_q; subkey_valid high
module des_key_schedule
  import des_key_schedule_pkg::*;
#(
  parameter bit PARITY_CHK = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        parity_err,
  output logic        busy
);

  ks_state_e   state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        par_q, par_d;
  logic [55:0] pc1_cd;

  assign pc1_cd = pc1(key_in);

  // State register and schedule datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      par_q   <= par_d;
    end
  end

  // Next state, load/rotate of C and D, and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    round_d      = round_q;
    dec_d        = dec_q;
    par_d        = par_q;
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          state_d = ST_RUN;
          // Decrypt starts from K16, which sits at the unrotated PC1 value.
          cd_d    = decrypt ? pc1_cd : rot_cd(pc1_cd, 1'b1, 1'b1);
          dec_d   = decrypt;
          round_d = '0;
          par_d   = PARITY_CHK && any_even_byte(key_in);
        end
      end
      ST_RUN: begin
        subkey_valid = 1'b1;
        busy         = 1'b1;
        if (subkey_ready) begin
          round_d = round_q + 4'd1;
          cd_d    = rot_cd(cd_q, !dec_q, single_shift(round_q));
          if (round_q == 4'(ROUNDS - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  des_key_schedule_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (subkey)
  );

  assign subkey_round = round_q;
  assign parity_err   = par_q;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        parity_err;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  des_key_schedule #(.PARITY_CHK(1'b1)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_round (subkey_round),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .parity_err   (parity_err),
    .busy         (busy)
  );

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  // Hand-derived K1..K16 for KEY_A.
  localparam logic [47:0] KA [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [3:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting (queue %0d entries left)", name, exp_q.size());
  endtask

  task automatic push_exp(input bit zero, input logic dec);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.rnd = 4'(i);
      e.sk  = zero ? 48'h0 : (dec ? KA[15 - i] : KA[i]);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare every presented subkey (stalled or accepted) to the queue head.
  always @(negedge sys_clk) begin
    if (sys_rst_n && subkey_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_subkey: got round %0d subkey %h, nothing expected",
                 subkey_round, subkey);
      end else begin
        if (subkey !== exp_q[0].sk || subkey_round !== exp_q[0].rnd) begin
          n_fail++;
          $display("FAIL subkey: got round %0d subkey %h expected round %0d subkey %h",
                   subkey_round, subkey, exp_q[0].rnd, exp_q[0].sk);
        end
        if (subkey_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present a key until accepted, then scramble the inputs to show they are latched.
  task automatic wait_accept(input logic dec);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      #1;
      if (key_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("load");
    @(posedge sys_clk);
    #1;
    key_valid = 1'b0;
    decrypt   = ~dec;
    key_in    = 64'hFEDCBA9876543210;
    @(negedge sys_clk);
    check("first_valid", 64'(subkey_valid), 64'd1);
    check("busy_run", 64'(busy), 64'd1);
    check("key_ready_run", 64'(key_ready), 64'd0);
  endtask

  task automatic load_key(input logic [63:0] k, input logic dec, input bit zero);
    @(posedge sys_clk);
    #1;
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    push_exp(zero, dec);
    wait_accept(dec);
  endtask

  task automatic run_out(input bit bp);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge sys_clk);
      #1;
      subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge sys_clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    subkey_ready = 1'b1;
    if (!ok) begin
      timeout("schedule");
      exp_q.delete();
    end else begin
      @(negedge sys_clk);
      check("key_ready_done", 64'(key_ready), 64'd1);
      check("valid_done", 64'(subkey_valid), 64'd0);
      check("busy_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    key_in       = '0;
    decrypt      = 1'b0;
    key_valid    = 1'b0;
    subkey_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_round", 64'(subkey_round), 64'd0);
    check("rst_parity", 64'(parity_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sys_rst_n = 1'b1;

    // Encrypt order, no backpressure.
    load_key(KEY_A, 1'b0, 1'b0);
    run_out(1'b0);
    check("parity_a", 64'(parity_err), 64'd0);

    // Decrypt order.
    load_key(KEY_A, 1'b1, 1'b0);
    run_out(1'b0);

    // Encrypt with random backpressure.
    load_key(KEY_A, 1'b0, 1'b0);
    run_out(1'b1);

    // New key offered at round 7 must wait; it is all-zero so parity_err must set.
    load_key(KEY_A, 1'b0, 1'b0);
    repeat (7) @(posedge sys_clk);
    #1;
    key_in    = 64'h0;
    decrypt   = 1'b0;
    key_valid = 1'b1;
    push_exp(1'b1, 1'b0);
    @(negedge sys_clk);
    check("key_ready_mid", 64'(key_ready), 64'd0);
    check("round_mid", 64'(subkey_round), 64'd7);
    wait_accept(1'b0);
    check("parity_zero_key", 64'(parity_err), 64'd1);
    run_out(1'b0);
    check("parity_held", 64'(parity_err), 64'd1);
    load_key(KEY_A, 1'b0, 1'b0);
    check("parity_cleared", 64'(parity_err), 64'd0);
    run_out(1'b0);

    // Asynchronous reset at round 5.
    load_key(KEY_A, 1'b0, 1'b0);
    repeat (5) @(posedge sys_clk);
    #1;
    check("round_before_rst", 64'(subkey_round), 64'd5);
    exp_q.delete();
    sys_rst_n = 1'b0;
    #1;
    check("arst_key_ready", 64'(key_ready), 64'd1);
    check("arst_valid", 64'(subkey_valid), 64'd0);
    check("arst_subkey", 64'(subkey), 64'd0);
    check("arst_round", 64'(subkey_round), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      check("post_rst_valid", 64'(subkey_valid), 64'd0);
      check("post_rst_ready", 64'(key_ready), 64'd1);
    end

    // Recovery after reset: decrypt order again.
    load_key(KEY_A, 1'b1, 1'b0);
    run_out(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
